// File: rtl/aes_enc_round_ctrl.sv
// aes_enc_round_ctrl: AES-256 round scheduler. Sequences the SB/SR/MC/ARK stage
// enables in AES order, steers the shared state register and drives the round-key index.
// Optional macro AES_CTRL_TIMEOUT_EN adds a sticky err output and a per-stage WAIT timeout.
module aes_enc_round_ctrl #(
  parameter int NR            = 14,
  parameter int STAGE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       st_load_in,
  output logic       st_load,
  output logic [1:0] st_sel,
  output logic [3:0] round_idx,
  output logic       sb_en,
  output logic       sr_en,
  output logic       mc_en,
  output logic       ark_en,
  input  logic       sb_done,
  input  logic       sr_done,
  input  logic       mc_done,
  input  logic       ark_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
`ifdef AES_CTRL_TIMEOUT_EN
  ,
  output logic       err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  // Stage codes double as the st_sel encoding of the state-register mux.
  localparam logic [1:0] STG_SB  = 2'd0;
  localparam logic [1:0] STG_SR  = 2'd1;
  localparam logic [1:0] STG_MC  = 2'd2;
  localparam logic [1:0] STG_ARK = 2'd3;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Reject round counts the 4-bit round index and AES do not support.
  if (!(NR == 10 || NR == 12 || NR == 14) || STAGE_TIMEOUT < 1) begin : g_param_check
    $error("aes_enc_round_ctrl: illegal NR or STAGE_TIMEOUT");
  end

  logic [1:0] state;
  logic [1:0] stage;
  logic [1:0] stage_nxt;
  logic       last_step;
  logic       cur_done;
  logic       active;
  logic       timeout_hit;

  assign active     = (state == S_ISSUE) || (state == S_WAIT);
  assign in_ready   = (state == S_IDLE);
  assign st_load_in = in_ready && in_valid;
  assign out_valid  = (state == S_OUT);
  assign busy       = (state != S_IDLE);
  assign st_load    = (state == S_WAIT) && cur_done;
  assign st_sel     = active ? stage : 2'd0;

  // The enable of the current stage is held through ISSUE and WAIT.
  assign sb_en  = active && (stage == STG_SB);
  assign sr_en  = active && (stage == STG_SR);
  assign mc_en  = active && (stage == STG_MC);
  assign ark_en = active && (stage == STG_ARK);

  // Select the done level of the stage currently being waited on.
  always_comb begin
    cur_done = 1'b0;
    case (stage)
      STG_SB:  cur_done = sb_done;
      STG_SR:  cur_done = sr_done;
      STG_MC:  cur_done = mc_done;
      default: cur_done = ark_done;
    endcase
  end

  // Stage successor: the final round skips MixColumns and ends after its ARK.
  always_comb begin
    stage_nxt = stage;
    last_step = 1'b0;
    case (stage)
      STG_SB:  stage_nxt = STG_SR;
      STG_SR:  stage_nxt = (round_idx == LAST_ROUND) ? STG_ARK : STG_MC;
      STG_MC:  stage_nxt = STG_ARK;
      default: begin
        stage_nxt = STG_SB;
        last_step = (round_idx == LAST_ROUND);
      end
    endcase
  end

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(STAGE_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout_hit = (state == S_WAIT) && !cur_done && (wait_cnt == CW'(STAGE_TIMEOUT - 1));

  // Count WAIT cycles without done; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state != S_WAIT) begin
        wait_cnt <= '0;
      end else if (!cur_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Main scheduler: accept, issue/wait each stage, present the result, abort on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      stage     <= STG_SB;
      round_idx <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_ISSUE;
            stage     <= STG_ARK;
            round_idx <= 4'd0;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cur_done) begin
            stage <= stage_nxt;
            if (last_step) begin
              state <= S_OUT;
            end else begin
              state <= S_ISSUE;
              if (stage == STG_ARK) begin
                round_idx <= round_idx + 4'd1;
              end
            end
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
